// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file: special-register
// index helpers and the stack-pointer update encoding.
package reg_file_pkg;

  // Stack-pointer next-state selection, resolved once per cycle.
  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_INC  = 2'd1,
    SP_DEC  = 2'd2,
    SP_LOAD = 2'd3
  } sp_op_e;

  // The stack pointer lives in the highest index.
  function automatic int sp_idx(input int num_regs);
    return num_regs - 1;
  endfunction

  // The data-segment register sits just below the stack pointer.
  function automatic int ds_idx(input int num_regs);
    return num_regs - 2;
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Decode-to-execute bus of the register file.
// Protocol: there is no valid/ready pairing. Every control input
// (reg_write, data_sel, stack_sel, sp_inc, sp_dec) is a level qualifier sampled
// on each rising clock edge together with the addresses and write data;
// rd_data_1/rd_data_2 are registered and valid from the edge after the
// sample until the following edge; sp_value is a live view of the SP.
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic              data_sel;
  logic              stack_sel;
  logic              sp_inc;
  logic              sp_dec;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic [DATA_W-1:0] sp_value;

  // Decode side drives addresses/controls and consumes read data.
  modport master (
    output reg_write, wr_addr, wr_data, rd_addr_1, rd_addr_2,
           data_sel, stack_sel, sp_inc, sp_dec,
    input  rd_data_1, rd_data_2, sp_value
  );

  // Register file side.
  modport slave (
    input  reg_write, wr_addr, wr_data, rd_addr_1, rd_addr_2,
           data_sel, stack_sel, sp_inc, sp_dec,
    output rd_data_1, rd_data_2, sp_value
  );
endinterface

// File: rtl/reg_word.sv
// One storage word of the register file: synchronous active-low reset to a
// per-instance value, otherwise loads d_i when load_i is high.
module reg_word #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] word_q;

  // Word storage with synchronous reset and load enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= RST_VAL;
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports,
// SP/DS at the top indices, hardware push/pop on SP, write-to-read bypass
// and an optional hardwired-zero R0.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(16'h07FF),
  parameter bit                ZERO_R0  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_param_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int SP_IDX = sp_idx(NUM_REGS);
  localparam int DS_IDX = ds_idx(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  // Value each register will hold after the current edge; the read muxes
  // select from this so same-cycle writes and SP updates are forwarded.
  logic [DATA_W-1:0] next_d [NUM_REGS];
  sp_op_e            sp_op;
  logic [DATA_W-1:0] rd_data_1_q, rd_data_1_d;
  logic [DATA_W-1:0] rd_data_2_q, rd_data_2_d;

  // SP update priority: explicit write, then a lone inc or dec; both cancel.
  always_comb begin
    sp_op = SP_HOLD;
    if (bus.reg_write && (bus.wr_addr == ADDR_W'(SP_IDX))) begin
      sp_op = SP_LOAD;
    end else if (bus.sp_inc && !bus.sp_dec) begin
      sp_op = SP_INC;
    end else if (bus.sp_dec && !bus.sp_inc) begin
      sp_op = SP_DEC;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_W-1:0] word_d;
    logic              word_load;

    if (g == SP_IDX) begin : g_sp
      // SP next value; arithmetic wraps modulo 2^DATA_W.
      always_comb begin
        word_d    = regs_q[g];
        word_load = 1'b0;
        unique case (sp_op)
          SP_LOAD: begin word_d = bus.wr_data;            word_load = 1'b1; end
          SP_INC:  begin word_d = regs_q[g] + DATA_W'(1); word_load = 1'b1; end
          SP_DEC:  begin word_d = regs_q[g] - DATA_W'(1); word_load = 1'b1; end
          default: begin word_d = regs_q[g];              word_load = 1'b0; end
        endcase
      end
    end else begin : g_gp
      // Plain write decode; R0 is never written when hardwired to zero.
      always_comb begin
        word_d    = bus.wr_data;
        word_load = bus.reg_write && (bus.wr_addr == ADDR_W'(g)) &&
                    !(ZERO_R0 && (g == 0));
      end
    end

    assign next_d[g] = word_load ? word_d : regs_q[g];

    reg_word #(
      .DATA_W  (DATA_W),
      .RST_VAL ((g == SP_IDX) ? SP_RESET : '0)
    ) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (word_load),
      .d_i    (word_d),
      .q_o    (regs_q[g])
    );
  end

  // Read source selection with bypass; stack_sel outranks data_sel.
  always_comb begin
    rd_data_1_d = next_d[bus.rd_addr_1];
    if (ZERO_R0 && (bus.rd_addr_1 == '0)) rd_data_1_d = '0;
    if (bus.data_sel)  rd_data_1_d = next_d[DS_IDX];
    if (bus.stack_sel) rd_data_1_d = next_d[SP_IDX];

    rd_data_2_d = next_d[bus.rd_addr_2];
    if (ZERO_R0 && (bus.rd_addr_2 == '0)) rd_data_2_d = '0;
    if (bus.stack_sel) rd_data_2_d = '0;
  end

  // Registered read ports, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
    end else begin
      rd_data_1_q <= rd_data_1_d;
      rd_data_2_q <= rd_data_2_d;
    end
  end

  assign bus.rd_data_1 = rd_data_1_q;
  assign bus.rd_data_2 = rd_data_2_q;
  assign bus.sp_value  = regs_q[SP_IDX];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build plus a ZERO_R0 build.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) bm ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) bz ();

  reg_file_param #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm)
  );

  reg_file_param #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(1'b1)) dut_z (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bz)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        ds;
    logic        ss;
    logic        inc;
    logic        dec;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] esp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic [3:0] ra1,
                              input logic [3:0] ra2, input logic ds,
                              input logic ss, input logic inc, input logic dec,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] esp);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
    v.ds = ds; v.ss = ss; v.inc = inc; v.dec = dec;
    v.e1 = e1; v.e2 = e2; v.esp = esp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input vec_t v);
    bm.reg_write = v.we;  bm.wr_addr   = v.wa;  bm.wr_data   = v.wd;
    bm.rd_addr_1 = v.ra1; bm.rd_addr_2 = v.ra2;
    bm.data_sel  = v.ds;  bm.stack_sel = v.ss;
    bm.sp_inc    = v.inc; bm.sp_dec    = v.dec;
  endtask

  task automatic idle_z();
    bz.reg_write = 1'b0; bz.wr_addr   = '0; bz.wr_data   = '0;
    bz.rd_addr_1 = '0;   bz.rd_addr_2 = '0;
    bz.data_sel  = 1'b0; bz.stack_sel = 1'b0;
    bz.sp_inc    = 1'b0; bz.sp_dec    = 1'b0;
  endtask

  initial begin
    //            we wa     wd       ra1    ra2    ds ss in de  e1        e2        esp
    vecs[0]  = mk(1, 4'd3,  16'hA5A5, 4'd0,  4'd0,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h07FF);
    vecs[1]  = mk(0, 4'd0,  16'h0000, 4'd3,  4'd3,  0, 0, 0, 0, 16'hA5A5, 16'hA5A5, 16'h07FF);
    vecs[2]  = mk(0, 4'd3,  16'hFFFF, 4'd3,  4'd3,  0, 0, 0, 0, 16'hA5A5, 16'hA5A5, 16'h07FF);
    vecs[3]  = mk(1, 4'd7,  16'h1234, 4'd3,  4'd7,  0, 0, 0, 0, 16'hA5A5, 16'h1234, 16'h07FF);
    vecs[4]  = mk(0, 4'd0,  16'h0000, 4'd7,  4'd3,  0, 0, 0, 1, 16'h1234, 16'hA5A5, 16'h07FE);
    vecs[5]  = mk(0, 4'd0,  16'h0000, 4'd0,  4'd0,  0, 0, 0, 1, 16'h0000, 16'h0000, 16'h07FD);
    vecs[6]  = mk(0, 4'd0,  16'h0000, 4'd3,  4'd7,  0, 0, 0, 1, 16'hA5A5, 16'h1234, 16'h07FC);
    vecs[7]  = mk(0, 4'd0,  16'h0000, 4'd0,  4'd0,  0, 0, 1, 1, 16'h0000, 16'h0000, 16'h07FC);
    vecs[8]  = mk(1, 4'd15, 16'h0000, 4'd15, 4'd15, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    vecs[9]  = mk(0, 4'd0,  16'h0000, 4'd15, 4'd15, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    vecs[10] = mk(0, 4'd0,  16'h0000, 4'd15, 4'd3,  0, 0, 1, 0, 16'h0000, 16'hA5A5, 16'h0000);
    vecs[11] = mk(0, 4'd0,  16'h0000, 4'd3,  4'd3,  0, 1, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF);
    vecs[12] = mk(1, 4'd14, 16'h0040, 4'd2,  4'd7,  1, 0, 0, 0, 16'h0040, 16'h1234, 16'hFFFF);
    vecs[13] = mk(0, 4'd0,  16'h0000, 4'd2,  4'd14, 1, 1, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF);
    vecs[14] = mk(0, 4'd0,  16'h0000, 4'd2,  4'd14, 1, 0, 0, 0, 16'h0040, 16'h0040, 16'hFFFF);
    vecs[15] = mk(1, 4'd2,  16'hBEEF, 4'd2,  4'd2,  0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 16'hFFFF);
    vecs[16] = mk(1, 4'd15, 16'h1000, 4'd3,  4'd3,  0, 1, 0, 1, 16'h1000, 16'h0000, 16'h1000);
    vecs[17] = mk(1, 4'd0,  16'hFFFF, 4'd0,  4'd0,  0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h1000);
    vecs[18] = mk(0, 4'd0,  16'h0000, 4'd5,  4'd5,  0, 1, 1, 0, 16'h1001, 16'h0000, 16'h1001);

    // Clock/reset: two reset edges with other inputs active to show they are ignored.
    rst_n = 1'b0;
    drive_m(mk(1, 4'd4, 16'hDEAD, 4'd4, 4'd4, 0, 0, 1, 0, 0, 0, 0));
    idle_z();
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("reset%0d rd1", c), bm.rd_data_1, 16'h0000);
      chk($sformatf("reset%0d rd2", c), bm.rd_data_2, 16'h0000);
      chk($sformatf("reset%0d sp", c),  bm.sp_value,  16'h07FF);
      chk($sformatf("reset%0d z sp", c), bz.sp_value, 16'h07FF);
    end
    rst_n = 1'b1;

    // Every general register and DS reads back zero after reset.
    for (int i = 0; i < 15; i++) begin
      drive_m(mk(0, 4'd0, 16'h0000, 4'(i), 4'(i), 0, 0, 0, 0, 0, 0, 0));
      step();
      chk($sformatf("post-reset R%0d rd1", i), bm.rd_data_1, 16'h0000);
      chk($sformatf("post-reset R%0d rd2", i), bm.rd_data_2, 16'h0000);
    end

    // Table-driven sequence on the default build.
    for (int i = 0; i < NV; i++) begin
      drive_m(vecs[i]);
      step();
      chk($sformatf("vec%0d rd1", i), bm.rd_data_1, vecs[i].e1);
      chk($sformatf("vec%0d rd2", i), bm.rd_data_2, vecs[i].e2);
      chk($sformatf("vec%0d sp", i),  bm.sp_value,  vecs[i].esp);
    end
    drive_m(mk(0, 4'd0, 16'h0000, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0));

    // Hardwired-zero R0: same-edge write and read of R0 gives zero.
    bz.reg_write = 1'b1; bz.wr_addr = 4'd0; bz.wr_data = 16'hFFFF;
    bz.rd_addr_1 = 4'd0; bz.rd_addr_2 = 4'd0;
    step();
    chk("z bypass R0 rd1", bz.rd_data_1, 16'h0000);
    chk("z bypass R0 rd2", bz.rd_data_2, 16'h0000);
    bz.reg_write = 1'b0;
    step();
    chk("z R0 rd1", bz.rd_data_1, 16'h0000);
    chk("z R0 rd2", bz.rd_data_2, 16'h0000);

    // R5 writable normally in the ZERO_R0 build.
    bz.reg_write = 1'b1; bz.wr_addr = 4'd5; bz.wr_data = 16'h1111;
    bz.rd_addr_1 = 4'd5; bz.rd_addr_2 = 4'd0;
    step();
    chk("z R5 bypass rd1", bz.rd_data_1, 16'h1111);
    chk("z R5 bypass rd2", bz.rd_data_2, 16'h0000);

    // Mid-stream reset with a pending write to R5 and an SP decrement.
    rst_n = 1'b0;
    bz.wr_data = 16'h5555; bz.sp_dec = 1'b1;
    step();
    chk("z reset rd1", bz.rd_data_1, 16'h0000);
    chk("z reset sp",  bz.sp_value,  16'h07FF);
    chk("main reset sp", bm.sp_value, 16'h07FF);
    rst_n = 1'b1;
    idle_z();
    bz.rd_addr_1 = 4'd5; bz.rd_addr_2 = 4'd5;
    bm.rd_addr_1 = 4'd2; bm.rd_addr_2 = 4'd7;
    step();
    chk("z R5 after reset rd1", bz.rd_data_1, 16'h0000);
    chk("z R5 after reset rd2", bz.rd_data_2, 16'h0000);
    chk("main R2 after reset", bm.rd_data_1, 16'h0000);
    chk("main R7 after reset", bm.rd_data_2, 16'h0000);
    chk("z sp after reset", bz.sp_value, 16'h07FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
